load_store_seq: RTL and testbench

- Load/store sequencer between the core's memory stage and the byte-wide data RAM.
- Converts one LB/LBU/LH/LHU/LW/SB/SH/SW request into a series of single-byte RAM accesses, little-endian.
- Returns the assembled, sign- or zero-extended 32-bit load result, or a store completion.
- Drives the RAM's wr_en/rd_en/wr_addr/rd_addr/din and consumes its registered dout (1-cycle read latency).

---
 rtl/load_store_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_load_store_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_seq.sv
// Load/store sequencer: turns one LB/LBU/LH/LHU/LW/SB/SH/SW request into a
// series of single-byte accesses to a byte-wide RAM (little-endian) and
// returns either the extended load result or a store completion.
module load_store_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int XLEN       = 32
) (
    input  logic                  PC,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int NBYTES = XLEN / DATA_WIDTH;
    localparam int CNT_W  = $clog2(NBYTES);

    // The byte lane logic below assumes a byte-wide RAM.
    generate
        if (DATA_WIDTH != 8) begin : g_dw_check
            $error("load_store_seq: only DATA_WIDTH == 8 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_LOAD_LAST,
        ST_RESP
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;          // byte index accessed this cycle
    logic [CNT_W-1:0]      last_reg, last_next;        // index of the final byte (N-1)
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [XLEN-1:0]       wdata_reg, wdata_next;
    logic [1:0]            size_reg, size_next;
    logic                  uns_reg, uns_next;
    logic [XLEN-1:0]       asm_reg, asm_next;          // load assembly register
    logic                  cap_valid_reg, cap_valid_next;  // ram_dout carries a byte this cycle
    logic [CNT_W-1:0]      cap_idx_reg, cap_idx_next;      // which byte ram_dout carries

    logic                  resp_valid_reg, resp_valid_next;
    logic                  resp_err_reg, resp_err_next;
    logic [XLEN-1:0]       resp_rdata_reg, resp_rdata_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  rd_en_reg, rd_en_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;

    logic [DATA_WIDTH-1:0] wbyte [NBYTES];
    logic [XLEN-1:0]       asm_ins;    // assembly register with this cycle's byte merged in
    logic [XLEN-1:0]       load_ext;   // asm_ins sign/zero-extended to XLEN
    logic [CNT_W-1:0]      idx_next;
    logic                  req_err;

    // Byte lanes: store data split into bytes and the incoming read byte merged into its lane.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign wbyte[gi] = wdata_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            assign asm_ins[gi*DATA_WIDTH +: DATA_WIDTH] =
                (cap_valid_reg && (cap_idx_reg == CNT_W'(gi))) ? ram_dout
                                                               : asm_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign idx_next = cnt_reg + CNT_W'(1);

    assign req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Extend the assembled load value from its natural width to XLEN.
    always_comb begin
        load_ext = asm_ins;
        case (size_reg)
            2'b00: load_ext = uns_reg ? {{(XLEN-8){1'b0}}, asm_ins[7:0]}
                                      : {{(XLEN-8){asm_ins[7]}}, asm_ins[7:0]};
            2'b01: load_ext = uns_reg ? {{(XLEN-16){1'b0}}, asm_ins[15:0]}
                                      : {{(XLEN-16){asm_ins[15]}}, asm_ins[15:0]};
            default: load_ext = asm_ins;
        endcase
    end

    // Next-state and registered-output logic; strobes default low, addresses hold.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_next       = last_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        size_next       = size_reg;
        uns_next        = uns_reg;
        asm_next        = asm_reg;
        cap_valid_next  = rd_en_reg;   // RAM answers one cycle after the read strobe
        cap_idx_next    = cnt_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        wr_en_next      = 1'b0;
        rd_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        rd_addr_next    = rd_addr_reg;
        din_next        = din_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    size_next  = req_size;
                    uns_next   = req_unsigned;
                    asm_next   = '0;
                    cnt_next   = '0;
                    case (req_size)
                        2'b00:   last_next = CNT_W'(0);
                        2'b01:   last_next = CNT_W'(1);
                        default: last_next = CNT_W'(NBYTES - 1);
                    endcase
                    if (req_err) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else if (req_we) begin
                        state_next   = ST_STORE;
                        wr_en_next   = 1'b1;
                        wr_addr_next = req_addr;
                        din_next     = req_wdata[DATA_WIDTH-1:0];
                    end else begin
                        state_next   = ST_LOAD;
                        rd_en_next   = 1'b1;
                        rd_addr_next = req_addr;
                    end
                end
            end
            ST_STORE: begin
                if (cnt_reg == last_reg) begin
                    state_next      = ST_RESP;
                    resp_valid_next = 1'b1;
                end else begin
                    cnt_next     = idx_next;
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr_reg + ADDR_WIDTH'(idx_next);
                    din_next     = wbyte[idx_next];
                end
            end
            ST_LOAD: begin
                asm_next = asm_ins;
                if (cnt_reg == last_reg) begin
                    state_next = ST_LOAD_LAST;
                end else begin
                    cnt_next     = idx_next;
                    rd_en_next   = 1'b1;
                    rd_addr_next = addr_reg + ADDR_WIDTH'(idx_next);
                end
            end
            ST_LOAD_LAST: begin
                asm_next        = asm_ins;
                state_next      = ST_RESP;
                resp_valid_next = 1'b1;
                resp_rdata_next = load_ext;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge PC or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_reg       <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            size_reg       <= '0;
            uns_reg        <= 1'b0;
            asm_reg        <= '0;
            cap_valid_reg  <= 1'b0;
            cap_idx_reg    <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            din_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_reg       <= last_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            size_reg       <= size_next;
            uns_reg        <= uns_next;
            asm_reg        <= asm_next;
            cap_valid_reg  <= cap_valid_next;
            cap_idx_reg    <= cap_idx_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            wr_en_reg      <= wr_en_next;
            rd_en_reg      <= rd_en_next;
            wr_addr_reg    <= wr_addr_next;
            rd_addr_reg    <= rd_addr_next;
            din_reg        <= din_next;
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign resp_valid  = resp_valid_reg;
    assign resp_err    = resp_err_reg;
    assign resp_rdata  = resp_rdata_reg;
    assign ram_wr_en   = wr_en_reg;
    assign ram_rd_en   = rd_en_reg;
    assign ram_wr_addr = wr_addr_reg;
    assign ram_rd_addr = rd_addr_reg;
    assign ram_din     = din_reg;

endmodule

// File: tb/tb_load_store_seq.sv
// Bench for load_store_seq: byte RAM model, directed plan, then random requests
// checked against a byte-array reference memory.
module tb_load_store_seq;

    logic        PC;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic [7:0]  ram_wr_addr;
    logic [7:0]  ram_rd_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int n_checks = 0;
    int n_errors = 0;

    bit [7:0] ram_mem [256];   // the RAM the DUT talks to
    bit [7:0] ref_mem [256];   // what memory should hold

    load_store_seq #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .XLEN(32)) dut (
        .PC(PC), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial PC = 1'b0;
    always #5 PC = ~PC;

    // Byte RAM with one-cycle registered read.
    always @(posedge PC) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= ram_mem[ram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input bit [7:0] a, input int n, input bit uns);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(ref_mem[8'(int'(a) + i)]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                          input bit [7:0] a, input bit [31:0] wd);
        int        n;
        int        lat;
        int        resp_k;
        bit        err;
        bit [31:0] exp_rd;
        bit        exp_wr_en;
        bit        exp_rd_en;
        bit [7:0]  ak;
        bit [31:0] got_rd;
        bit        got_err;

        n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err    = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
        lat    = err ? 1 : (we ? n + 1 : n + 2);
        exp_rd = (err || we) ? 32'h0 : model_load(a, n, uns);
        got_rd = 32'h0;
        got_err = 1'b0;

        @(negedge PC);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge PC);
        #1;
        req_valid = 1'b0;

        resp_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge PC);
            exp_wr_en = !err && we && k <= n;
            exp_rd_en = !err && !we && k <= n;
            ak = 8'(int'(a) + k - 1);
            check("wr_en", {31'b0, ram_wr_en}, {31'b0, exp_wr_en});
            check("rd_en", {31'b0, ram_rd_en}, {31'b0, exp_rd_en});
            if (exp_wr_en) begin
                check("wr_addr", {24'b0, ram_wr_addr}, {24'b0, ak});
                check("din", {24'b0, ram_din}, {24'b0, wd[8*(k-1) +: 8]});
            end
            if (exp_rd_en)
                check("rd_addr", {24'b0, ram_rd_addr}, {24'b0, ak});
            if (resp_valid) begin
                resp_k  = k;
                got_rd  = resp_rdata;
                got_err = resp_err;
                check("resp_err", {31'b0, resp_err}, {31'b0, err});
                check("resp_rdata", resp_rdata, exp_rd);
                break;
            end
        end
        check("latency", resp_k, lat);
        @(negedge PC);
        check("ready_after_resp", {31'b0, req_ready}, 32'd1);
        check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);

        if (!err && we)
            for (int i = 0; i < n; i++) ref_mem[8'(int'(a) + i)] = wd[8*i +: 8];

        $display("req we=%0d size=%0d uns=%0d addr=%02h wdata=%08h : latency=%0d err=%0d rdata=%08h",
                 we, sz, uns, a, wd, resp_k, got_err, got_rd);
    endtask

    initial begin
        bit        r_we;
        bit [1:0]  r_sz;
        bit [7:0]  r_a;

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 8'h00;
        req_wdata    = 32'h0;

        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_wr_en", {31'b0, ram_wr_en}, 32'd0);
        check("rst_rd_en", {31'b0, ram_rd_en}, 32'd0);
        check("rst_wr_addr", {24'b0, ram_wr_addr}, 32'd0);
        check("rst_rd_addr", {24'b0, ram_rd_addr}, 32'd0);
        check("rst_din", {24'b0, ram_din}, 32'd0);
        @(negedge PC);
        rst = 1'b1;

        // Directed plan
        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);   // SW
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);          // LW
        do_req(1'b0, 2'b00, 1'b0, 8'h13, 32'h0);          // LB
        do_req(1'b0, 2'b00, 1'b1, 8'h13, 32'h0);          // LBU
        do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'h0);          // LH
        do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'h0);          // LHU
        do_req(1'b0, 2'b10, 1'b0, 8'h11, 32'h0);          // misaligned LW
        do_req(1'b1, 2'b01, 1'b0, 8'h03, 32'h12345678);   // misaligned SH
        do_req(1'b0, 2'b11, 1'b0, 8'h00, 32'h0);          // illegal size
        do_req(1'b1, 2'b00, 1'b0, 8'hFF, 32'h0000007F);   // SB at top address
        do_req(1'b0, 2'b00, 1'b0, 8'hFF, 32'h0);          // LB at top address

        // Reset in the middle of a word load
        @(negedge PC);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 8'h10;
        @(posedge PC);
        #1;
        req_valid = 1'b0;
        @(posedge PC);          // start of cycle 2
        #2;
        rst = 1'b0;
        #1;
        check("abort_rd_en", {31'b0, ram_rd_en}, 32'd0);
        check("abort_wr_en", {31'b0, ram_wr_en}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge PC);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge PC);
            check("post_abort_strobes", {30'b0, ram_rd_en, ram_wr_en}, 32'd0);
            check("post_abort_resp", {31'b0, resp_valid}, 32'd0);
            check("post_abort_ready", {31'b0, req_ready}, 32'd1);
        end
        $display("reset mid-load: strobes dropped, no response, idle");

        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);          // stored word intact

        // Random requests against the reference memory
        for (int t = 0; t < 60; t++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (r_sz == 2'b01) r_a[0] = 1'b0;
                if (r_sz == 2'b10) r_a[1:0] = 2'b00;
            end
            do_req(r_we, r_sz, 1'($urandom_range(0, 1)), r_a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
